// File: rtl/sequence_detection_unit.sv
// Four-byte marker detector: pulses flag for one cycle after BYTE1..BYTE4 arrive on consecutive clocks.
// Latency: flag is high in the cycle after the edge that samples BYTE4 (Moore output, registered state).
// Backpressure: none; one byte is consumed every clock with no valid qualifier and no stall.
module sequence_detection_unit #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BYTE1      = 8'hAB,
  parameter logic [DATA_WIDTH-1:0] BYTE2      = 8'hCD,
  parameter logic [DATA_WIDTH-1:0] BYTE3      = 8'hEF,
  parameter logic [DATA_WIDTH-1:0] BYTE4      = 8'h24
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  flag
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GOT1  = 3'd1;
  localparam logic [2:0] GOT2  = 3'd2;
  localparam logic [2:0] GOT3  = 3'd3;
  localparam logic [2:0] FOUND = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       is_byte1;

  // A byte equal to BYTE1 always restarts a match; the in-order pattern check is tested first.
  assign is_byte1 = (data == BYTE1);

  // Next-state: advance on the expected byte, else restart on BYTE1, else fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (is_byte1) state_d = GOT1;
      end
      GOT1: begin
        if (data == BYTE2) state_d = GOT2;
        else if (is_byte1) state_d = GOT1;
      end
      GOT2: begin
        if (data == BYTE3) state_d = GOT3;
        else if (is_byte1) state_d = GOT1;
      end
      GOT3: begin
        if (data == BYTE4) state_d = FOUND;
        else if (is_byte1) state_d = GOT1;
      end
      FOUND: begin
        if (is_byte1) state_d = GOT1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any partial match at once, without waiting for an edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flag is a pure decode of the state register, so it has no path from data.
  assign flag = (state_q == FOUND);

endmodule

// File: tb/tb_sequence_detection_unit.sv
module tb_sequence_detection_unit;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] data;
  logic       flag;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] PAT [4] = '{8'hAB, 8'hCD, 8'hEF, 8'h24};

  typedef struct {
    logic [7:0] d;
    logic       exp_flag;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] hist[$];

  sequence_detection_unit dut (
    .clk  (clk),
    .nrst (nrst),
    .data (data),
    .flag (flag)
  );

  always #5 clk = ~clk;

  // Reference: flag follows iff the last four bytes since reset spell the pattern.
  task automatic model_push(input logic [7:0] b, output logic e);
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
    e = (hist.size() == 4);
    for (int i = 0; i < 4; i++)
      if (hist.size() == 4 && hist[i] != PAT[i]) e = 1'b0;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: flag=%0b expected=%0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one byte, let one rising edge sample it, then look at flag.
  task automatic cycle(input logic [7:0] b, input string name);
    logic e;
    data = b;
    @(posedge clk);
    #1;
    model_push(b, e);
    check(name, flag, e);
  endtask

  task automatic cycle_exp(input logic [7:0] b, input logic exp, input string name);
    logic e;
    data = b;
    @(posedge clk);
    #1;
    model_push(b, e);
    check(name, flag, exp);
  endtask

  task automatic cycle_in_reset(input logic [7:0] b, input string name);
    data = b;
    @(posedge clk);
    #1;
    check(name, flag, 1'b0);
    hist.delete();
  endtask

  task automatic add(input logic [7:0] d, input logic f);
    vec_t v;
    v.d = d;
    v.exp_flag = f;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] burst[4];
    int         r;

    // Stream with an aborted partial match
    add(8'h88,0); add(8'hAB,0); add(8'hA2,0); add(8'hAB,0);
    add(8'hCD,0); add(8'hEF,0); add(8'h24,1); add(8'hAB,0);
    // Broken sequence then a good one
    add(8'hAB,0); add(8'hCD,0); add(8'h44,0);
    add(8'hAB,0); add(8'hCD,0); add(8'hEF,0); add(8'h24,1);
    // Restart on repeated first byte
    add(8'hAB,0); add(8'hAB,0); add(8'hCD,0); add(8'hEF,0); add(8'h24,1);
    // Back-to-back sequences, pulses four clocks apart
    add(8'hAB,0); add(8'hCD,0); add(8'hEF,0); add(8'h24,1);
    add(8'hAB,0); add(8'hCD,0); add(8'hEF,0); add(8'h24,1);
    // BYTE1 arriving in GOT3 restarts the match
    add(8'hAB,0); add(8'hCD,0); add(8'hEF,0); add(8'hAB,0);
    add(8'hCD,0); add(8'hEF,0); add(8'h24,1);
    // Last byte off by one bit
    add(8'hAB,0); add(8'hCD,0); add(8'hEF,0); add(8'h25,0); add(8'h24,0);

    nrst = 1'b1;
    data = 8'h00;
    #1 nrst = 1'b0;
    #1 check("reset_async", flag, 1'b0);
    cycle_in_reset(8'hAB, "reset_hold");
    #2 nrst = 1'b1;

    foreach (vecs[i]) cycle_exp(vecs[i].d, vecs[i].exp_flag, $sformatf("vec%0d", i));

    // Reset mid-cycle after a three-byte partial match; bytes during reset never count.
    cycle_exp(8'hAB, 1'b0, "rst_pre1");
    cycle_exp(8'hCD, 1'b0, "rst_pre2");
    cycle_exp(8'hEF, 1'b0, "rst_pre3");
    #3 nrst = 1'b0;
    #1 check("rst_mid_async", flag, 1'b0);
    hist.delete();
    cycle_in_reset(8'h0C, "rst_low0");
    cycle_in_reset(8'hAB, "rst_low1");
    cycle_in_reset(8'hCD, "rst_low2");
    cycle_in_reset(8'hEF, "rst_low3");
    cycle_in_reset(8'h24, "rst_low4");
    cycle_in_reset(8'hAB, "rst_low5");
    #3 nrst = 1'b1;
    // State must be IDLE: the tail of the pattern alone must not fire.
    cycle_exp(8'hCD, 1'b0, "post_rst_cd");
    cycle_exp(8'hEF, 1'b0, "post_rst_ef");
    cycle_exp(8'h24, 1'b0, "post_rst_24");
    cycle_exp(8'hAB, 1'b0, "post_rst_ab");
    cycle_exp(8'hCD, 1'b0, "post_rst_cd2");
    cycle_exp(8'hEF, 1'b0, "post_rst_ef2");
    cycle_exp(8'h24, 1'b1, "post_rst_hit");

    // Reset while flag is high truncates the pulse immediately.
    #2 nrst = 1'b0;
    #1 check("rst_in_found", flag, 1'b0);
    hist.delete();
    #1 nrst = 1'b1;

    // Randomized bursts against the reference model
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        for (int k = 0; k < 4; k++) burst[k] = PAT[k];
        if ($urandom_range(0, 2) == 0) burst[$urandom_range(0, 3)] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 4; k++) cycle(burst[k], "rand_burst");
      end else if (r == 9 && $urandom_range(0, 9) == 0) begin
        #2 nrst = 1'b0;
        #1 check("rand_reset", flag, 1'b0);
        hist.delete();
        #1 nrst = 1'b1;
      end else begin
        r = $urandom_range(0, 4);
        if (r < 4) cycle(PAT[r], "rand_pool");
        else       cycle(8'($urandom_range(0, 255)), "rand_byte");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_detection_unit.md
# sequence_detection_unit

Byte-stream pattern detector. Samples one data byte per clock and raises a single-cycle `flag` when the four-byte sequence BYTE1, BYTE2, BYTE3, BYTE4 (default 0xAB, 0xCD, 0xEF, 0x24) has arrived on consecutive clocks. It sits on a byte-wide receive path as a sync/header marker detector.

## Interface
- `DATA_WIDTH`, 8: width of `data` and of each pattern byte.
- `BYTE1`, 8'hAB: first pattern byte.
- `BYTE2`, 8'hCD: second pattern byte.
- `BYTE3`, 8'hEF: third pattern byte.
- `BYTE4`, 8'h24: fourth pattern byte.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `data`  in  DATA_WIDTH  input byte, sampled on every rising `clk` edge; no valid qualifier.
- `flag`  out  1  detection pulse, high for one cycle per completed sequence.

## Operation
- Moore FSM with five states: IDLE, GOT1, GOT2, GOT3, FOUND.
- Transitions are evaluated on each rising edge with the sampled `data`:
  - IDLE: `data`==BYTE1 -> GOT1; otherwise stay in IDLE.
  - GOT1: BYTE2 -> GOT2; BYTE1 -> GOT1; otherwise -> IDLE.
  - GOT2: BYTE3 -> GOT3; BYTE1 -> GOT1; otherwise -> IDLE.
  - GOT3: BYTE4 -> FOUND; BYTE1 -> GOT1; otherwise -> IDLE.
  - FOUND: BYTE1 -> GOT1; otherwise -> IDLE.
- The pattern-byte check takes priority over the BYTE1 restart check. This matters only if parameters repeat bytes.
- Overlap handling:
  - A mismatching byte that equals BYTE1 restarts the match at GOT1.
  - Any other mismatch returns to IDLE.
  - No other partial-overlap recovery is performed.
- Back-to-back sequences are detected. BYTE1 received in FOUND continues into a new match.
- `flag` = (state == FOUND), driven directly from the state register. It has no combinational path from `data`.
- Every byte is compared in full; there are no don't-care bits.

## Timing
- Reset:
  - `nrst` low forces state to IDLE and `flag` to 0 immediately, without waiting for a clock edge.
  - While `nrst` is low, state stays IDLE and `flag` stays 0 regardless of `data` or `clk`.
  - After `nrst` deasserts, the first rising edge samples `data` normally.
- Latency:
  - `flag` rises in the cycle after the rising edge that samples BYTE4.
  - It stays high for exactly one clock period, unless the sequence completes again, which requires at least 4 more clocks.
- Minimum spacing between two `flag` pulses is 4 clocks, with `flag` low for 3 clocks in between.
- Reset mid-sequence discards all partial progress. Bytes sampled before reset never count toward a later match.
- Reset asserted while in FOUND clears `flag` immediately, truncating the pulse.

## Test plan
- Stream 0x88, 0xAB, 0xA2, 0xAB, 0xCD, 0xEF, 0x24, 0xAB (one byte per clock, after reset):
  - `flag` is 0 throughout, except one cycle right after 0x24 is sampled.
  - The 0xA2 aborts the first partial match.
- Broken sequence 0xAB, 0xCD, 0x44, followed by 0xAB, 0xCD, 0xEF, 0x24:
  - No `flag` for the broken part.
  - Exactly one `flag` pulse after the final 0x24.
- Restart on repeated first byte 0xAB, 0xAB, 0xCD, 0xEF, 0x24 -> one `flag` pulse after 0x24.
- Back-to-back 0xAB, 0xCD, 0xEF, 0x24, 0xAB, 0xCD, 0xEF, 0x24 -> two one-cycle pulses, 4 clocks apart.
- Assert `nrst` low mid-cycle (not on an edge) after 0xAB, 0xCD, 0xEF, then drive 0x0C, 0xAB, 0xCD, 0xEF, 0x24, 0xAB while `nrst` stays low:
  - `flag` stays 0 throughout.
  - State reads IDLE throughout.
- Assert `nrst` while `flag`=1 -> `flag` drops to 0 without waiting for a clock edge.
